gpr_wb_arbiter: RTL

//  Shares the single GPR write port among NREQ writeback requesters (EXU/ALU, LSU, CSR unit) in round-robin order.

---
 rtl/gpr_wb_arbiter_pkg.sv | 12 +
 rtl/gpr_wb_arbiter_if.sv | 28 ++
 rtl/gpr_wb_arbiter_rr_arbiter.sv | 31 +++
 rtl/gpr_wb_arbiter.sv | 82 ++++++++
 4 files changed

// File: rtl/gpr_wb_arbiter_pkg.sv
// gpr_wb_pkg: shared constants and the writeback payload type for the GPR writeback arbiter
package gpr_wb_pkg;
    localparam int DEF_NREQ = 3;
    localparam int DEF_XLEN = 32;
    localparam int DEF_AW   = 5;
    localparam int PTR_W    = $clog2(DEF_NREQ);
    typedef struct packed {
        logic [DEF_AW-1:0]   addr;
        logic [DEF_XLEN-1:0] data;
        logic [DEF_XLEN-1:0] pc;
    } wb_req_t;
endpackage

// File: rtl/gpr_wb_arbiter_if.sv
// gpr_wb_arbiter_if: requester handshake plus regfile/commit bus of the writeback arbiter
// master: requesters and sink (drive req_valid/req_addr/req_data/req_pc/wb_ready)
// slave:  arbiter (drives req_ready, gpr_wen/gpr_waddr/gpr_wdata, commit_valid/commit_pc)
interface gpr_wb_arbiter_if #(
    parameter int NREQ = 3,
    parameter int XLEN = 32,
    parameter int AW   = 5
);
    logic [NREQ-1:0]      req_valid;
    logic [NREQ-1:0]      req_ready;
    logic [NREQ*AW-1:0]   req_addr;
    logic [NREQ*XLEN-1:0] req_data;
    logic [NREQ*XLEN-1:0] req_pc;
    logic                 wb_ready;
    logic                 gpr_wen;
    logic [AW-1:0]        gpr_waddr;
    logic [XLEN-1:0]      gpr_wdata;
    logic                 commit_valid;
    logic [XLEN-1:0]      commit_pc;
    modport master (
        output req_valid, req_addr, req_data, req_pc, wb_ready,
        input  req_ready, gpr_wen, gpr_waddr, gpr_wdata, commit_valid, commit_pc
    );
    modport slave (
        input  req_valid, req_addr, req_data, req_pc, wb_ready,
        output req_ready, gpr_wen, gpr_waddr, gpr_wdata, commit_valid, commit_pc
    );
endinterface

// File: rtl/gpr_wb_arbiter_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick of the first set req bit at or after ptr (wrapping)
// in: req[N], ptr, en   out: gnt[N] one-hot, gnt_idx, any
module rr_arbiter #(
    parameter int N  = 3,
    parameter int PW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    input  logic          en,
    output logic [N-1:0]  gnt,
    output logic [PW-1:0] gnt_idx,
    output logic          any
);
    logic [PW-1:0] idx;
    // scan farthest-first so the candidate nearest ptr is written last and wins
    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        any     = 1'b0;
        idx     = '0;
        for (int k = N - 1; k >= 0; k--) begin
            idx = PW'((int'(ptr) + k) % N);
            if (en && req[idx]) begin
                gnt      = '0;
                gnt[idx] = 1'b1;
                gnt_idx  = idx;
                any      = 1'b1;
            end
        end
    end
endmodule

// File: rtl/gpr_wb_arbiter.sv
// gpr_wb_arbiter: round-robin share of the GPR write port among NREQ writeback requesters
// clk, reset (sync, active-low); bus: gpr_wb_arbiter_if.slave (request handshake, regfile write, commit)
// GPR_WB_COMMIT_CNT_EN: adds commit_cnt[63:0] (retired instructions) and x0_drop_cnt[31:0] (retired x0 writes)
module gpr_wb_arbiter
    import gpr_wb_pkg::*;
#(
    parameter int NREQ = DEF_NREQ,
    parameter int XLEN = DEF_XLEN,
    parameter int AW   = DEF_AW
) (
    input  logic                  clk,
    input  logic                  reset,
    gpr_wb_arbiter_if.slave       bus
`ifdef GPR_WB_COMMIT_CNT_EN
    ,
    output logic [63:0]           commit_cnt,
    output logic [31:0]           x0_drop_cnt
`endif
);
    localparam int PW = $clog2(NREQ);
    logic            out_v_q, out_v_d;
    logic [AW-1:0]   out_addr_q, out_addr_d;
    logic [XLEN-1:0] out_data_q, out_data_d;
    logic [XLEN-1:0] out_pc_q, out_pc_d;
    logic [PW-1:0]   rr_ptr_q, rr_ptr_d;
    logic [PW-1:0]   win;
    logic            hs, drain, accept;
    assign drain  = out_v_q & bus.wb_ready;
    assign accept = ~out_v_q | bus.wb_ready;
    // grants are suppressed while reset is held so nothing is consumed and then discarded
    rr_arbiter #(.N(NREQ), .PW(PW)) u_arb (
        .req    (bus.req_valid),
        .ptr    (rr_ptr_q),
        .en     (accept & reset),
        .gnt    (bus.req_ready),
        .gnt_idx(win),
        .any    (hs)
    );
    always_comb begin
        out_v_d    = hs | (out_v_q & ~bus.wb_ready);
        out_addr_d = hs ? bus.req_addr[int'(win)*AW +: AW] : out_addr_q;
        out_data_d = hs ? bus.req_data[int'(win)*XLEN +: XLEN] : out_data_q;
        out_pc_d   = hs ? bus.req_pc[int'(win)*XLEN +: XLEN] : out_pc_q;
        rr_ptr_d   = hs ? ((int'(win) == NREQ - 1) ? '0 : win + 1'b1) : rr_ptr_q;
    end
    always_ff @(posedge clk) begin
        if (!reset) begin
            out_v_q    <= 1'b0;
            out_addr_q <= '0;
            out_data_q <= '0;
            out_pc_q   <= '0;
            rr_ptr_q   <= '0;
        end else begin
            out_v_q    <= out_v_d;
            out_addr_q <= out_addr_d;
            out_data_q <= out_data_d;
            out_pc_q   <= out_pc_d;
            rr_ptr_q   <= rr_ptr_d;
        end
    end
    // x0 writes retire through commit but never reach the regfile
    assign bus.gpr_wen      = drain & (|out_addr_q);
    assign bus.gpr_waddr    = out_addr_q;
    assign bus.gpr_wdata    = out_data_q;
    assign bus.commit_valid = drain;
    assign bus.commit_pc    = out_pc_q;
`ifdef GPR_WB_COMMIT_CNT_EN
    logic [63:0] commit_cnt_q;
    logic [31:0] x0_drop_cnt_q;
    always_ff @(posedge clk) begin
        if (!reset) begin
            commit_cnt_q  <= '0;
            x0_drop_cnt_q <= '0;
        end else begin
            commit_cnt_q  <= commit_cnt_q + 64'(drain);
            x0_drop_cnt_q <= x0_drop_cnt_q + 32'(drain & ~(|out_addr_q));
        end
    end
    assign commit_cnt  = commit_cnt_q;
    assign x0_drop_cnt = x0_drop_cnt_q;
`endif
endmodule
